// File: rtl/sound_ram_dma_if.sv
// Bundle of command, stream and RAM-port signals for the sound RAM DMA engine.
// master: the DMA engine side. slave: the environment (host, stream
// endpoints and RAM).
interface sound_ram_dma_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    // command
    logic              start;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] fill_value;
    // write-stream source
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    // read-stream sink
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    // synchronous RAM port
    logic [ADDR_W-1:0] ram_address;
    logic              ram_write;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;
    // status
    logic              busy;
    logic              done;

    modport master (
        input  start, cmd, base_addr, length, fill_value,
        input  in_valid, in_data, out_ready, ram_q,
        output in_ready, out_valid, out_data,
        output ram_address, ram_write, ram_data, busy, done
    );

    modport slave (
        output start, cmd, base_addr, length, fill_value,
        output in_valid, in_data, out_ready, ram_q,
        input  in_ready, out_valid, out_data,
        input  ram_address, ram_write, ram_data, busy, done
    );
endinterface

// File: rtl/sound_ram_dma.sv
// Sound RAM DMA engine: fills a RAM region with a constant, streams words
// into RAM, or streams words out of a synchronous (1-cycle latency) RAM.
// Addresses wrap modulo 2^ADDR_W.
module sound_ram_dma #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sound_ram_dma_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WSTR,
        S_RADDR,
        S_RDATA,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] fill_q,  fill_d;
    logic [DATA_W-1:0] rdat_q,  rdat_d;
    // set once the RAM word of the current RDATA visit has been captured
    logic              held_q,  held_d;

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            fill_q  <= '0;
            rdat_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            rdat_q  <= rdat_d;
            held_q  <= held_d;
        end
    end

    // Next-state logic: command dispatch, per-beat address/count stepping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        fill_d  = fill_q;
        rdat_d  = rdat_q;
        held_d  = held_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    count_d = bus.length;
                    fill_d  = bus.fill_value;
                    if (bus.length == '0) begin
                        state_d = S_FIN;
                    end else begin
                        unique case (bus.cmd)
                            2'b00:   state_d = S_FILL;
                            2'b01:   state_d = S_WSTR;
                            2'b10:   state_d = S_RADDR;
                            default: state_d = S_FIN;
                        endcase
                    end
                end
            end
            S_FILL: begin
                addr_d  = addr_q + ADDR_ONE;
                count_d = count_q - COUNT_ONE;
                if (count_q == COUNT_ONE) state_d = S_FIN;
            end
            S_WSTR: begin
                if (bus.in_valid) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_q - COUNT_ONE;
                    if (count_q == COUNT_ONE) state_d = S_FIN;
                end
            end
            S_RADDR: begin
                held_d  = 1'b0;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                // ram_q is valid from the first RDATA cycle; freeze it there
                if (!held_q) begin
                    rdat_d = bus.ram_q;
                    held_d = 1'b1;
                end
                if (bus.out_ready) begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_q - COUNT_ONE;
                    held_d  = 1'b0;
                    state_d = (count_q == COUNT_ONE) ? S_FIN : S_RADDR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state so reset clears them without a clock edge.
    always_comb begin
        bus.ram_address = addr_q;
        bus.ram_write   = 1'b0;
        bus.ram_data    = '0;
        bus.in_ready    = (state_q == S_WSTR);
        bus.out_valid   = (state_q == S_RDATA);
        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_FIN);
        // first RDATA cycle passes ram_q through; later cycles show the capture
        bus.out_data    = (state_q == S_RDATA && !held_q) ? bus.ram_q : rdat_q;
        if (state_q == S_FILL) begin
            bus.ram_write = 1'b1;
            bus.ram_data  = fill_q;
        end else if (state_q == S_WSTR && bus.in_valid) begin
            bus.ram_write = 1'b1;
            bus.ram_data  = bus.in_data;
        end
    end

endmodule

// File: tb/tb_sound_ram_dma.sv
// Bench for sound_ram_dma: behavioural RAM, expected-write/expected-read
// queues filled by the stimulus and drained by a negedge monitor.
module tb_sound_ram_dma;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   nwr = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    wr_t               exp_wr [$];
    logic [DATA_W-1:0] exp_rd [$];
    int                wcyc [$];

    sound_ram_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sound_ram_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAM, registered q
    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every RAM write and every accepted read word is scored
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_write) begin
                nwr++;
                wcyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", {21'd0, bus.ram_address}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", {21'd0, bus.ram_address}, {21'd0, e.a});
                    check("wr_data", {24'd0, bus.ram_data}, {24'd0, e.d});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [DATA_W-1:0] d;
                    d = exp_rd.pop_front();
                    check("rd_data", {24'd0, bus.out_data}, {24'd0, d});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (bus.done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [10:0] base, input logic [11:0] len,
                         input logic [7:0] val);
        bus.cmd        = c;
        bus.base_addr  = base;
        bus.length     = len;
        bus.fill_value = val;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic push_wr(input logic [10:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
        check({tag, "_done"},      {31'd0, bus.done},      32'd0);
        check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_ram_write"}, {31'd0, bus.ram_write}, 32'd0);
        check({tag, "_ram_addr"},  {21'd0, bus.ram_address}, 32'd0);
        check({tag, "_ram_data"},  {24'd0, bus.ram_data},  32'd0);
        check({tag, "_out_data"},  {24'd0, bus.out_data},  32'd0);
    endtask

    initial begin
        int n;
        int base_wr;
        int cnt;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[2]         = 8'h3C;
        bus.ram_q      = '0;
        bus.start      = 1'b0;
        bus.cmd        = 2'b00;
        bus.base_addr  = '0;
        bus.length     = '0;
        bus.fill_value = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;

        // reset state, before any clock edge
        #3;
        check_all_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;

        // fill across the wrap point; a start while busy must be ignored
        wcyc.delete();
        push_wr(11'h7FE, 8'hA5);
        push_wr(11'h7FF, 8'hA5);
        push_wr(11'h000, 8'hA5);
        push_wr(11'h001, 8'hA5);
        issue(2'b00, 11'h7FE, 12'd4, 8'hA5);
        check("fill_busy", {31'd0, bus.busy}, 32'd1);
        bus.start      = 1'b1;
        bus.cmd        = 2'b01;
        bus.base_addr  = 11'h100;
        bus.length     = 12'd1;
        bus.fill_value = 8'h55;
        n = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) bus.start = 1'b0;
            if (bus.done) begin
                n = k;
                break;
            end
        end
        check("fill_done_latency", n, 32'd4);
        tick();
        check("fill_done_pulse", {31'd0, bus.done}, 32'd0);
        check("fill_idle", {31'd0, bus.busy}, 32'd0);
        check("fill_nwrites", wcyc.size(), 32'd4);
        if (wcyc.size() == 4) check("fill_consecutive", wcyc[3] - wcyc[0], 32'd3);
        check("fill_mem_002", {24'd0, mem[2]}, 32'h3C);
        check("fill_mem_100", {24'd0, mem[11'h100]}, 32'h00);
        check("fill_mem_7FF", {24'd0, mem[11'h7FF]}, 32'hA5);
        check("fill_mem_001", {24'd0, mem[11'h001]}, 32'hA5);

        // write-stream with a stalling source
        base_wr = nwr;
        push_wr(11'h010, 8'h11);
        push_wr(11'h011, 8'h22);
        push_wr(11'h012, 8'h33);
        issue(2'b01, 11'h010, 12'd3, 8'h00);
        check("wstr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1; bus.in_data = 8'h11; tick();
        bus.in_valid = 1'b0; bus.in_data = 8'hEE; tick();
        bus.in_valid = 1'b1; bus.in_data = 8'h22; tick();
        bus.in_valid = 1'b1; bus.in_data = 8'h33; tick();
        bus.in_valid = 1'b0;
        check("wstr_done", {31'd0, bus.done}, 32'd1);
        check("wstr_in_ready_fin", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("wstr_nwrites", nwr - base_wr, 32'd3);
        check("wstr_mem10", {24'd0, mem[11'h010]}, 32'h11);
        check("wstr_mem11", {24'd0, mem[11'h011]}, 32'h22);
        check("wstr_mem12", {24'd0, mem[11'h012]}, 32'h33);

        // read-stream with the sink stalled on the first word
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        issue(2'b10, 11'h010, 12'd3, 8'h00);
        check("rd_raddr_no_valid", {31'd0, bus.out_valid}, 32'd0);
        n = -1;
        for (int k = 1; k <= 5; k++) begin
            if (bus.out_valid) begin
                n = k;
                break;
            end
            tick();
        end
        check("rd_first_valid_seen", {31'd0, (n > 0)}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("rd_stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("rd_stall_data", {24'd0, bus.out_data}, 32'h11);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_done(12, n);
        check("rd_done_seen", {31'd0, (n > 0)}, 32'd1);
        check("rd_queue_empty", exp_rd.size(), 32'd0);
        bus.out_ready = 1'b0;
        tick();

        // reserved command and zero length complete without RAM activity
        base_wr = nwr;
        issue(2'b11, 11'h020, 12'd5, 8'h77);
        check("rsv_done", {31'd0, bus.done}, 32'd1);
        tick();
        check("rsv_done_pulse", {31'd0, bus.done}, 32'd0);
        issue(2'b00, 11'h020, 12'd0, 8'h77);
        check("len0_done", {31'd0, bus.done}, 32'd1);
        tick();
        check("len0_idle", {31'd0, bus.busy}, 32'd0);
        check("noop_nwrites", nwr - base_wr, 32'd0);

        // reset in the middle of a 16-beat fill, after 5 beats
        base_wr = nwr;
        for (int i = 0; i < 5; i++) push_wr(11'h200 + 11'(i), 8'h77);
        issue(2'b00, 11'h200, 12'd16, 8'h77);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) if (mem[11'h200 + 11'(i)] == 8'h77) cnt++;
        check("abort_locations", cnt, 32'd5);
        check("abort_nwrites", nwr - base_wr, 32'd5);
        issue(2'b11, 11'h000, 12'd1, 8'h00);
        check("post_reset_accept", {31'd0, bus.done}, 32'd1);
        tick();
        push_wr(11'h300, 8'h99);
        push_wr(11'h301, 8'h99);
        issue(2'b00, 11'h300, 12'd2, 8'h99);
        wait_done(6, n);
        check("post_reset_fill_latency", n, 32'd2);
        tick();
        check("post_reset_mem", {24'd0, mem[11'h301]}, 32'h99);
        check("wr_queue_empty", exp_wr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sound_ram_dma.md
SOUND_RAM_DMA -- requirements
Module: sound_ram_dma

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM address width (2048 locations).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, command strobe, sampled only in IDLE.
REQ-006 SHALL have port cmd, input, 2, operation: 00 fill, 01 write-stream, 10 read-stream, 11 reserved.
REQ-007 SHALL have port base_addr, input, ADDR_W, first RAM address.
REQ-008 SHALL have port length, input, ADDR_W+1, transfer count, 0..2048.
REQ-009 SHALL have port fill_value, input, DATA_W, constant written by fill.
REQ-010 SHALL have ports in_valid (input, 1), in_data (input, DATA_W) and in_ready (output, 1), the write-stream source handshake.
REQ-011 SHALL have ports out_valid (output, 1), out_data (output, DATA_W) and out_ready (input, 1), the read-stream sink handshake.
REQ-012 SHALL have ports ram_address (output, ADDR_W), ram_write (output, 1), ram_data (output, DATA_W) and ram_q (input, DATA_W), driving a synchronous RAM whose q is registered with 1-cycle read latency and which writes on the clk edge when write=1.
REQ-013 SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a 1-cycle pulse at command completion.

Function
REQ-014 SHALL implement the states IDLE, FILL, WSTR, RADDR, RDATA and FIN.
REQ-015 In IDLE, a start=1 with cmd 00/01/10 and length>0 SHALL latch cmd, base_addr, length and fill_value, load addr=base_addr and count=length, and enter FILL, WSTR or RADDR respectively.
REQ-016 A start with length=0 or cmd=11 SHALL go to FIN with no RAM write and no stream handshake.
REQ-017 Start SHALL be ignored whenever busy=1.
REQ-018 FILL: ram_write=1 and ram_data=latched fill_value each cycle; addr increments and count decrements each cycle; after the write with count=1, the block SHALL enter FIN, giving exactly length writes in length cycles.
REQ-019 WSTR: in_ready=1; on in_valid&in_ready, ram_write=1 and ram_data=in_data in that same cycle, then addr++ and count--; the last beat SHALL enter FIN; in_ready=0 in every other state.
REQ-020 RADDR: drive ram_address=addr with ram_write=0 for one cycle, then enter RDATA.
REQ-021 RDATA: on entry, capture ram_q into out_data and assert out_valid; hold out_data/out_valid stable until out_ready=1; on acceptance, addr++ and count--, then go to RADDR, or to FIN if count was 1.
REQ-022 out_valid SHALL be 0 outside RDATA; a word is delivered at most every 2 cycles plus sink stall.
REQ-023 addr SHALL wrap modulo 2^ADDR_W (2047 -> 0); a length of 2048 covers every location exactly once.
REQ-024 ram_address SHALL equal addr in every state; ram_write SHALL be 0 in IDLE, RADDR, RDATA and FIN.
REQ-025 FIN: done=1 for exactly one cycle, then IDLE; busy=1 in FIN and 0 in IDLE.
REQ-026 Latched command fields SHALL be immune to input changes during busy.

Reset
REQ-027 On reset_n=0, regardless of clk, the block SHALL force state=IDLE, addr=0, count=0, and set busy, done, in_ready, out_valid and ram_write to 0, with out_data=0 and ram_data=0.
REQ-028 Reset mid-transfer SHALL abort with no further RAM write; the partial contents are not rolled back.
REQ-029 After reset_n rises, the first start SHALL be accepted on the next clk edge.

Verification
REQ-030 Fill: base 0x7FE, length 4, value 0xA5 -> writes to 0x7FE, 0x7FF, 0x000, 0x001 on 4 consecutive cycles; done pulses 1 cycle later; location 0x002 is unchanged.
REQ-031 Write-stream with a stalling source (in_valid 1,0,1,1), base 0x010, length 3, data 11/22/33 -> RAM[0x10..0x12] = 11, 22, 33; exactly 3 write pulses.
REQ-032 Read-stream: length 3 from 0x010 with out_ready held 0 for 5 cycles on the first word -> out_data = 0x11 stays stable while stalled, then 0x22 and 0x33 follow, then done.
REQ-033 cmd=11 or length=0 -> done 1 cycle after start; ram_write never asserts; a start while busy is ignored.
REQ-034 reset_n pulsed low during a fill of 16 beats at beat 5 -> outputs are zero immediately; exactly 5 locations are written; a following start runs normally.
